alu_pwr_ctrl: RTL and testbench

//   Power-sequencing controller for the switchable ALU domain; generates the alu_pwr_en and iso_en inputs the ALU wrapper consumes.

---
 rtl/alu_pwr_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_alu_pwr_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pwr_ctrl.sv
// ---------------------------------------------------------------------------
// alu_pwr_ctrl
//   Power-sequencing controller for the switchable ALU domain. Orders
//   isolation, supply switching and domain reset so the ALU wrapper never
//   sees an unisolated, unpowered ALU. Lives in the always-on domain.
//
// Ports
//   clk         in   1  clock
//   rst         in   1  asynchronous, active-high reset
//   pd_req      in   1  level request: power the ALU domain down
//   pu_req      in   1  level request: power the ALU domain up
//   alu_busy    in   1  ALU busy flag; power-down waits while high
//   alu_pwr_en  out  1  ALU supply switch enable
//   iso_en      out  1  ALU output isolation enable
//   alu_rst_n   out  1  ALU domain reset, active-low
//   ready       out  1  high only in ON
//   done        out  1  1-cycle pulse on entry to ON or OFF (not on reset)
//   busy_to     out  1  1-cycle pulse on forced power-down (timeout build)
//   state       out  3  current FSM state encoding, for debug
//
// Build option
//   ALU_PWR_TIMEOUT_EN : bound the busy-wait in ON to BUSY_TO_CYC cycles,
//                        then force power-down and pulse busy_to. When not
//                        defined the busy-wait is unbounded and busy_to is 0.
//
// State table
//   state    | enc | pwr/iso/rst_n | meaning
//   S_OFF    |  0  |   0/1/0       | domain off and isolated
//   S_PWR_UP |  1  |   1/1/0       | supply on, waiting for it to settle
//   S_RST_HLD|  2  |   1/1/0       | supply settled, domain reset still held
//   S_DE_ISO |  3  |   1/1/1       | reset released while still isolated
//   S_ON     |  4  |   1/0/1       | domain usable, ready=1
//   S_ISO    |  5  |   1/1/1       | isolated, waiting before supply drops
// ---------------------------------------------------------------------------
module alu_pwr_ctrl #(
  parameter int ISO_SETUP_CYC = 2,
  parameter int PWR_UP_CYC    = 8,
  parameter int RST_HOLD_CYC  = 2,
  parameter int BUSY_TO_CYC   = 64,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pd_req,
  input  logic       pu_req,
  input  logic       alu_busy,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       alu_rst_n,
  output logic       ready,
  output logic       done,
  output logic       busy_to,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_PWR_UP  = 3'd1,
    S_RST_HLD = 3'd2,
    S_DE_ISO  = 3'd3,
    S_ON      = 3'd4,
    S_ISO     = 3'd5
  } pwr_state_e;

  localparam logic [CNT_W-1:0] PWR_UP_LD   = CNT_W'(PWR_UP_CYC - 1);
  localparam logic [CNT_W-1:0] RST_HOLD_LD = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] ISO_LD      = CNT_W'(ISO_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Largest value any down-counter is ever loaded with.
  localparam int MAX_A  = (PWR_UP_CYC > RST_HOLD_CYC) ? PWR_UP_CYC : RST_HOLD_CYC;
  localparam int MAX_B  = (ISO_SETUP_CYC > BUSY_TO_CYC) ? ISO_SETUP_CYC : BUSY_TO_CYC;
  localparam int MAX_LD = ((MAX_A > MAX_B) ? MAX_A : MAX_B) - 1;

  if (ISO_SETUP_CYC < 1 || PWR_UP_CYC < 1 || RST_HOLD_CYC < 1 ||
      BUSY_TO_CYC < 1 || CNT_W < 1 || CNT_W > 31 || MAX_LD >= (1 << CNT_W)) begin : g_param_chk
    $error("alu_pwr_ctrl: parameter out of range");
  end

  pwr_state_e       cur_st;
  pwr_state_e       nxt_st;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] nxt_timer;
  logic             timer_tc;
  logic             to_fire;

  assign timer_tc = (timer == '0);

  // -------------------------------------------------------------------------
  // Busy-wait timeout: down-counter reloaded whenever the ON/pd_req/alu_busy
  // wait condition is broken, so only consecutive cycles count.
  // -------------------------------------------------------------------------
`ifdef ALU_PWR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] BUSY_LD = CNT_W'(BUSY_TO_CYC - 1);

  logic [CNT_W-1:0] busy_cnt;
  logic             busy_wait;

  assign busy_wait = (cur_st == S_ON) && pd_req && alu_busy;
  assign to_fire   = busy_wait && (busy_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= BUSY_LD;
      busy_to  <= 1'b0;
    end else begin
      busy_cnt <= (busy_wait && !to_fire) ? (busy_cnt - CNT_ONE) : BUSY_LD;
      busy_to  <= to_fire;
    end
  end
`else
  assign to_fire = 1'b0;
  assign busy_to = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next state / timer
  // -------------------------------------------------------------------------
  always_comb begin
    nxt_st    = cur_st;
    nxt_timer = timer;
    case (cur_st)
      S_OFF: begin
        // pu_req wins when both requests are high; pd_req means nothing here.
        if (pu_req) begin
          nxt_st    = S_PWR_UP;
          nxt_timer = PWR_UP_LD;
        end
      end
      S_PWR_UP: begin
        if (timer_tc) begin
          nxt_st    = S_RST_HLD;
          nxt_timer = RST_HOLD_LD;
        end else begin
          nxt_timer = timer - CNT_ONE;
        end
      end
      S_RST_HLD: begin
        if (timer_tc) nxt_st = S_DE_ISO;
        else          nxt_timer = timer - CNT_ONE;
      end
      S_DE_ISO: begin
        nxt_st = S_ON;
      end
      S_ON: begin
        // pd_req wins when both requests are high; a busy ALU holds us here
        // unless the timeout build has given up waiting.
        if (pd_req && (!alu_busy || to_fire)) begin
          nxt_st    = S_ISO;
          nxt_timer = ISO_LD;
        end
      end
      S_ISO: begin
        if (timer_tc) nxt_st = S_OFF;
        else          nxt_timer = timer - CNT_ONE;
      end
      default: begin
        nxt_st    = S_OFF;
        nxt_timer = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register with outputs decoded from the next state, so every output
  // is a flop that always matches the state register it sits beside.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_st     <= S_OFF;
      timer      <= '0;
      alu_pwr_en <= 1'b0;
      iso_en     <= 1'b1;
      alu_rst_n  <= 1'b0;
      ready      <= 1'b0;
      done       <= 1'b0;
    end else begin
      cur_st     <= nxt_st;
      timer      <= nxt_timer;
      alu_pwr_en <= (nxt_st != S_OFF);
      iso_en     <= (nxt_st != S_ON);
      alu_rst_n  <= (nxt_st == S_DE_ISO) || (nxt_st == S_ON) || (nxt_st == S_ISO);
      ready      <= (nxt_st == S_ON);
      done       <= (nxt_st != cur_st) && ((nxt_st == S_ON) || (nxt_st == S_OFF));
    end
  end

  assign state = cur_st;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
module tb_alu_pwr_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pd_req = 1'b0;
  logic       pu_req = 1'b0;
  logic       alu_busy = 1'b0;
  logic       alu_pwr_en;
  logic       iso_en;
  logic       alu_rst_n;
  logic       ready;
  logic       done;
  logic       busy_to;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  alu_pwr_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pd_req     (pd_req),
    .pu_req     (pu_req),
    .alu_busy   (alu_busy),
    .alu_pwr_en (alu_pwr_en),
    .iso_en     (iso_en),
    .alu_rst_n  (alu_rst_n),
    .ready      (ready),
    .done       (done),
    .busy_to    (busy_to),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pu;
    logic       pd;
    logic       busy;
    logic [2:0] st;
    logic       pwr;
    logic       iso;
    logic       rstn;
    logic       rdy;
    logic       dn;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input int pu, input int pd, input int busy, input int st,
                              input int pwr, input int iso, input int rstn,
                              input int rdy, input int dn);
    vec_t v;
    v.pu   = pu[0];
    v.pd   = pd[0];
    v.busy = busy[0];
    v.st   = st[2:0];
    v.pwr  = pwr[0];
    v.iso  = iso[0];
    v.rstn = rstn[0];
    v.rdy  = rdy[0];
    v.dn   = dn[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {state, pwr, iso, rst_n, ready, done}
  function automatic logic [7:0] outs();
    return {state, alu_pwr_en, iso_en, alu_rst_n, ready, done};
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int pwr_at, rstn_at, rdy_at;
    logic iso_at_rstn;

    //          pu pd bz | st pwr iso rstn rdy dn
    vecs[0]  = mk(0, 0, 0,  0, 0,  1,  0,  0,  0);
    vecs[1]  = mk(1, 0, 0,  1, 1,  1,  0,  0,  0);
    for (int i = 2; i <= 8; i++)
      vecs[i] = mk(1, 0, 0, 1, 1,  1,  0,  0,  0);
    vecs[9]  = mk(1, 0, 0,  2, 1,  1,  0,  0,  0);
    vecs[10] = mk(1, 0, 0,  2, 1,  1,  0,  0,  0);
    vecs[11] = mk(1, 0, 0,  3, 1,  1,  1,  0,  0);
    vecs[12] = mk(1, 0, 0,  4, 1,  0,  1,  1,  1);
    vecs[13] = mk(1, 0, 0,  4, 1,  0,  1,  1,  0);
    vecs[14] = mk(0, 1, 1,  4, 1,  0,  1,  1,  0);
    vecs[15] = mk(1, 1, 0,  5, 1,  1,  1,  0,  0);
    vecs[16] = mk(0, 1, 0,  5, 1,  1,  1,  0,  0);
    vecs[17] = mk(0, 1, 0,  0, 0,  1,  0,  0,  1);
    vecs[18] = mk(0, 1, 0,  0, 0,  1,  0,  0,  0);
    vecs[19] = mk(1, 1, 0,  1, 1,  1,  0,  0,  0);

    // Reset values
    step();
    chk("reset_outs", 32'(outs()), 32'({3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    chk("reset_busy_to", 32'(busy_to), 32'(0));
    rst = 1'b0;

    // Idle after reset: stays OFF, done never pulses
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("idle%0d", i), 32'(outs()), 32'({3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    end

    // Table: full power-up, busy hold, power-down, re-request
    for (int i = 0; i < 20; i++) begin
      pu_req   = vecs[i].pu;
      pd_req   = vecs[i].pd;
      alu_busy = vecs[i].busy;
      step();
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({vecs[i].st, vecs[i].pwr, vecs[i].iso, vecs[i].rstn, vecs[i].rdy, vecs[i].dn}));
      chk($sformatf("vec%0d_busy_to", i), 32'(busy_to), 32'(0));
    end

    // Reset mid-PWR_UP, then clean restart with pu_req held
    pd_req = 1'b0;
    pu_req = 1'b1;
    alu_busy = 1'b0;
    step(); step(); step();
    chk("pre_rst_state", 32'(state), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outs", 32'(outs()), 32'({3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    rst = 1'b0;
    pwr_at = -1; rstn_at = -1; rdy_at = -1; iso_at_rstn = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (alu_pwr_en && pwr_at < 0) pwr_at = k;
      if (alu_rst_n && rstn_at < 0) begin
        rstn_at = k;
        iso_at_rstn = iso_en;
      end
      if (ready) begin
        rdy_at = k;
        break;
      end
    end
    chk("restart_pwr_at", 32'(pwr_at), 32'(1));
    chk("restart_rstn_at", 32'(rstn_at), 32'(11));
    chk("restart_iso_at_rstn", 32'(iso_at_rstn), 32'(1));
    chk("restart_ready_at", 32'(rdy_at), 32'(12));
    chk("restart_done", 32'(done), 32'(1));
    pu_req = 1'b0;

    // Busy hold for 10 cycles, then ISO one cycle after busy drops
    pd_req = 1'b1;
    alu_busy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("busy_hold%0d", k), 32'({state, ready, iso_en}), 32'({3'd4, 1'b1, 1'b0}));
    end
    alu_busy = 1'b0;
    step();
    chk("busy_drop_iso", 32'(outs()), 32'({3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}));
    step();
    step();
    chk("busy_drop_off", 32'(outs()), 32'({3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}));
    pd_req = 1'b0;

    // Busy stuck with pd_req high
    pu_req = 1'b1;
    wait_ready(n);
    chk("to_pu_latency", 32'(n), 32'(12));
    pu_req = 1'b0;
    pd_req = 1'b1;
    alu_busy = 1'b1;
`ifdef ALU_PWR_TIMEOUT_EN
    n = 0;
    while (!busy_to && n < 100) begin
      step();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(64));
    chk("timeout_state", 32'(state), 32'(5));
    step();
    chk("timeout_pulse_width", 32'(busy_to), 32'(0));
    step();
    chk("timeout_off", 32'(outs()), 32'({3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}));
`else
    for (int k = 0; k < 80; k++) begin
      step();
      chk($sformatf("no_timeout%0d", k), 32'({state, busy_to}), 32'({3'd4, 1'b0}));
    end
    alu_busy = 1'b0;
    step();
    chk("no_timeout_release", 32'(state), 32'(5));
`endif
    pd_req = 1'b0;
    alu_busy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
